// File: rtl/line_scan_controller.sv
// line_scan_controller: raster read-address sequencer with pixel-valid alignment pipeline.
// Optional macro LSC_LINE_GAP_EN inserts one idle GAP cycle between lines.
`default_nettype none

module line_scan_controller #(
    parameter int LINE_SIZE    = 640,
    parameter int NUM_OF_LINES = 480,
    parameter int RD_LATENCY   = 2,
    localparam int NUM_PIX     = LINE_SIZE * NUM_OF_LINES,
    localparam int ADDR_W      = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1,
    localparam int LINE_W      = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1,
    localparam int PIX_W       = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              line_last,
    output logic              frame_last,
    output logic [LINE_W-1:0] line_idx,
    output logic              acc_clear,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
`ifdef LSC_LINE_GAP_EN
    localparam logic [2:0] S_GAP   = 3'd2;
`endif
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [PIX_W-1:0]      c_LAST_PIX  = PIX_W'(LINE_SIZE - 1);
    localparam logic [LINE_W-1:0]     c_LAST_LINE = LINE_W'(NUM_OF_LINES - 1);
    // Every stage except the output one; DRAIN ends once only the output stage can hold data.
    localparam logic [RD_LATENCY-1:0] c_UPSTREAM  = {RD_LATENCY{1'b1}} >> 1;

    logic [2:0]            state_q, state_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [RD_LATENCY-1:0] valid_q, valid_d;
    logic [RD_LATENCY-1:0] ll_q, ll_d;
    logic [RD_LATENCY-1:0] fl_q, fl_d;

    logic w_last_pix;
    logic w_last_line;
    logic w_kill;

    assign w_last_pix  = (pix_q == c_LAST_PIX);
    assign w_last_line = (line_q == c_LAST_LINE);
    assign w_kill      = abort && (state_q != S_IDLE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            ll_q    <= '0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            ll_q    <= ll_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SCAN;
                    pix_d   = '0;
                    line_d  = '0;
                    addr_d  = '0;
                end
            end
            S_SCAN: begin
                if (rd_en) begin
                    if (w_last_pix && w_last_line) begin
                        state_d = S_DRAIN;
                    end else if (w_last_pix) begin
                        pix_d  = '0;
                        line_d = line_q + 1'b1;
                        addr_d = addr_q + 1'b1;
`ifdef LSC_LINE_GAP_EN
                        state_d = S_GAP;
`endif
                    end else begin
                        pix_d  = pix_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef LSC_LINE_GAP_EN
            S_GAP:   state_d = S_SCAN;
`endif
            S_DRAIN: begin
                if ((valid_q & c_UPSTREAM) == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_kill) state_d = S_IDLE;

        // Shift in the current read with its tags; the MSB falls out at the output.
        valid_d = RD_LATENCY'({valid_q, rd_en});
        ll_d    = RD_LATENCY'({ll_q, rd_en && w_last_pix});
        fl_d    = RD_LATENCY'({fl_q, rd_en && w_last_pix && w_last_line});
        if (w_kill) begin
            valid_d = '0;
            ll_d    = '0;
            fl_d    = '0;
        end
    end

    always_comb begin
        rd_en      = (state_q == S_SCAN) && !pause && !abort;
        acc_clear  = rd_en && (pix_q == '0) && (line_q == '0);
        rd_addr    = addr_q;
        line_idx   = line_q;
        pix_valid  = valid_q[RD_LATENCY-1];
        line_last  = ll_q[RD_LATENCY-1];
        frame_last = fl_q[RD_LATENCY-1];
        done_valid = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
    end

endmodule

`default_nettype wire

// File: doc/line_scan_controller.md
# line_scan_controller

Sequences the line-sum datapath over one frame. On `start` it issues `LINE_SIZE*NUM_OF_LINES` pixel read addresses in raster order to the pixel-pair memories, and delays the read strobe to form `pix_valid`, aligned with the data returned into the line multiplier/adder. It tags the last pixel of each line and of the frame, pulses `acc_clear` at frame start for the line-sum accumulator, and signals frame completion with a valid/ready handshake to the result consumer.

## Interface
- `LINE_SIZE`, 640: pixels per line.
- `NUM_OF_LINES`, 480: lines per frame.
- `RD_LATENCY`, 2: memory read latency in cycles, ≥1.
- `CLK` in 1: clock.
- `reset` in 1: reset; one clock; reset is synchronous and active-high.
- `start` in 1: frame request; honoured only in IDLE.
- `abort` in 1: cancel the current frame.
- `pause` in 1: stall address generation.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out `ADDR_W = max(1,$clog2(LINE_SIZE*NUM_OF_LINES))`: read address `line*LINE_SIZE + pixel`.
- `pix_valid` out 1: returned data valid, `rd_en` delayed by `RD_LATENCY`.
- `line_last` out 1: with `pix_valid`, marks the last pixel of a line.
- `frame_last` out 1: with `pix_valid`, marks the last pixel of the frame.
- `line_idx` out `max(1,$clog2(NUM_OF_LINES))`: line currently being read.
- `acc_clear` out 1: one-cycle pulse on the first read of a frame.
- `done_valid` out 1: frame complete.
- `done_ready` in 1: consumer accepts completion.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, SCAN, GAP (`LSC_LINE_GAP_EN` only), DRAIN, DONE.
- IDLE: when `start=1` and `abort=0`, go to SCAN and clear the pixel and line counters.
- SCAN: `rd_en = !pause && !abort`.
  - Each cycle with `rd_en=1`, the pixel counter advances.
  - At pixel `LINE_SIZE-1`, the pixel counter wraps to 0 and the line counter increments.
  - After the read of the last pixel of the last line, go to DRAIN.
  - While paused, counters and `rd_addr` hold.
- DRAIN: wait until the valid pipeline is empty, i.e. the last `pix_valid` has been emitted, then go to DONE.
- DONE: `done_valid=1`, held until `done_ready=1`; then go to IDLE. `start` is ignored in DONE, including on the cycle of the handshake.
- `acc_clear` = `rd_en` AND pixel counter = 0 AND line counter = 0.
- Valid pipeline: a `RD_LATENCY`-deep shift register carrying {valid, line_last, frame_last}.
  - It shifts every cycle, including during pause, so in-flight reads still emerge.
  - `line_last` and `frame_last` are 0 whenever `pix_valid=0`.
- `abort` from any non-IDLE state: state goes to IDLE and the shift register clears on the next edge. No `done_valid` is produced for the aborted frame. `abort` has priority over `start`, `pause` and `done_ready`.
- Reset, including mid-frame: all outputs are 0, state is IDLE, counters are 0, and the pipeline is cleared.

## Timing
- Frame of N = `LINE_SIZE*NUM_OF_LINES` reads, no pause, `start` high at cycle t:
  - Reads are issued at cycles t+1 .. t+N.
  - The read at address k has `pix_valid` at t+1+k+`RD_LATENCY`.
  - `done_valid` first rises at t+N+`RD_LATENCY`+1.
- Each pause cycle in SCAN adds exactly one cycle to every later event.
- `LSC_LINE_GAP_EN` adds `NUM_OF_LINES-1` cycles per frame.
- Back-to-back frames: when the `done_ready` handshake happens at cycle u, a `start` at u+1 issues its first read at u+2.
- `rd_en` depends combinationally on `pause` and `abort`. All other outputs are registered or derived from state.

## Configuration
- `LSC_LINE_GAP_EN` defined: after the last read of each line except the final line, the FSM spends exactly one cycle in GAP.
  - In GAP, `rd_en=0`, so the line adder can flush.
  - `pause` is ignored in GAP.
  - `abort` in GAP behaves as in SCAN.
- Undefined: there is no GAP state and lines are read back-to-back.

## Test plan
All scenarios use `LINE_SIZE=4`, `NUM_OF_LINES=3`, `RD_LATENCY=2`, with `start` at cycle 0.
- Nominal frame:
  - `rd_addr` 0..11 at cycles 1..12; `acc_clear` at cycle 1.
  - `pix_valid` at cycles 3..14; `line_last` at 6, 10, 14; `frame_last` at 14.
  - `done_valid` at 15; `done_ready` at 15 → `busy=0` at 16.
- `pause` high at cycles 3–4:
  - `rd_en=0` at cycles 3–4; addr 2 at cycle 5; addr 11 at cycle 14.
  - `pix_valid` at cycles 3 and 4 from the reads in flight.
  - `done_valid` at 17.
- `done_ready` held low for 5 cycles after 15:
  - `done_valid` and `busy` stay high; `start` pulses at 17 and 19 are ignored.
  - `done_ready` at 20 → IDLE at 21.
- `abort` at cycle 6:
  - `rd_en=0` at 6; `busy=0` and `pix_valid=0` from cycle 7; no `done_valid`.
  - A later `start` restarts the frame at addr 0 with `acc_clear`.
- `reset` at cycle 8 mid-frame: every output is 0 from cycle 9.
- `LSC_LINE_GAP_EN`:
  - `rd_en=0` at cycles 5 and 10; addr 4 at 6; addr 8 at 11.
  - `frame_last` at 16; `done_valid` at 17.
